issue_scoreboard_n: RTL and testbench

Parametrised in-order issue stage between ID and the execution units (N_ALU ALUs, N_MEM memory units, single ROB/CDB domain).
- Holds the architectural register file plus a per-register busy/tag scoreboard.
- Picks a free unit of the right class and forwards ready operands, either from the register file or bypassed from any of N_WB writeback ports.
- Stalls ID when no unit is free.
- Blocks further issue after a control-flow instruction until the branch is resolved.

---
 rtl/issue_scoreboard_n.sv | 214 +++++++++++++++++++++
 tb/tb_issue_scoreboard_n.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard_n.sv
// In-order issue stage: register file, busy/tag scoreboard, unit allocation,
// writeback bypass and branch blocking.
module issue_scoreboard_n #(
    parameter int unsigned N_ALU  = 3,
    parameter int unsigned N_MEM  = 1,
    parameter int unsigned N_WB   = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned UNIT_W = $clog2(N_ALU + N_MEM + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    output logic                       id_ready,
    input  logic [ADDR_W-1:0]          id_pc,
    input  logic [6:0]                 id_opcode,
    input  logic [2:0]                 id_funct3,
    input  logic [DATA_W-1:0]          id_imm,
    input  logic [4:0]                 id_rs1,
    input  logic [4:0]                 id_rs2,
    input  logic [4:0]                 id_rd,
    input  logic [N_WB-1:0]            wb_valid,
    input  logic [N_WB*5-1:0]          wb_reg,
    input  logic [N_WB*DATA_W-1:0]     wb_data,
    input  logic [N_WB*UNIT_W-1:0]     wb_unit,
    input  logic [N_ALU+N_MEM-1:0]     unit_free,
    input  logic                       br_resolve,
    output logic [N_ALU+N_MEM-1:0]     iss_valid,
    output logic [CNT_W-1:0]           iss_seq,
    output logic [ADDR_W-1:0]          iss_pc,
    output logic [DATA_W-1:0]          iss_imm,
    output logic [6:0]                 iss_opcode,
    output logic [2:0]                 iss_funct3,
    output logic [4:0]                 iss_rd,
    output logic [DATA_W-1:0]          iss_rs1_val,
    output logic [DATA_W-1:0]          iss_rs2_val,
    output logic [UNIT_W-1:0]          iss_rs1_tag,
    output logic [UNIT_W-1:0]          iss_rs2_tag,
    output logic                       iss_jflag
);

    localparam int unsigned N_UNIT = N_ALU + N_MEM;
    localparam int unsigned N_REG  = 32;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_BR_WAIT = 1'b1;

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [0:0]              state_q, state_d;
    logic [DATA_W-1:0]       regs_q [N_REG];
    logic [UNIT_W-1:0]       tag_q  [N_REG];
    logic [N_REG-1:0]        busy_q;
    logic [N_UNIT-1:0]       unit_busy_q;
    logic [CNT_W-1:0]        seq_q;

    logic                    is_alu, is_mem, is_jmp, is_nop;
    logic                    sel_found;
    logic [UNIT_W-1:0]       sel_idx;
    logic [UNIT_W-1:0]       sel_tag;
    logic [N_UNIT-1:0]       sel_onehot;
    logic                    accept, issue, rd_set;
    logic [N_REG-1:0]        wb_hit;
    logic [DATA_W-1:0]       wb_dat [N_REG];
    logic [DATA_W-1:0]       op_val [2];
    logic [UNIT_W-1:0]       op_tag [2];
    logic [4:0]              op_rs  [2];
    logic [CNT_W-1:0]        seq_next;

    // Opcode classification
    always_comb begin
        is_alu = 1'b0;
        is_mem = 1'b0;
        is_jmp = 1'b0;
        case (id_opcode)
            7'b0010011, 7'b0110111, 7'b0010111, 7'b0110011: is_alu = 1'b1;
            7'b1101111, 7'b1100111, 7'b1100011: begin
                is_alu = 1'b1;
                is_jmp = 1'b1;
            end
            7'b0000011, 7'b0100011: is_mem = 1'b1;
            default: ;
        endcase
        is_nop = !is_alu && !is_mem;
    end

    // Lowest-indexed free unit of the requested class
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int u = int'(N_UNIT) - 1; u >= 0; u--) begin
            if (!unit_busy_q[u] && ((is_alu && u < int'(N_ALU)) || (is_mem && u >= int'(N_ALU)))) begin
                sel_found = 1'b1;
                sel_idx   = UNIT_W'(u);
            end
        end
        sel_tag    = sel_idx + UNIT_W'(1);
        sel_onehot = N_UNIT'(1) << sel_idx;
    end

    assign id_ready = (state_q == ST_RUN) && id_valid && (is_nop || sel_found);
    assign accept   = id_ready;
    assign issue    = accept && !is_nop;
    assign rd_set   = issue && (id_rd != 5'd0) && (id_opcode != OP_STORE) && (id_opcode != OP_BRANCH);
    assign seq_next = (seq_q == {CNT_W{1'b1}}) ? CNT_W'(1) : seq_q + CNT_W'(1);

    // Per-register writeback match; lowest port wins on multiple matches
    always_comb begin
        wb_hit = '0;
        for (int r = 0; r < int'(N_REG); r++) begin
            wb_dat[r] = '0;
        end
        for (int r = 1; r < int'(N_REG); r++) begin
            for (int p = int'(N_WB) - 1; p >= 0; p--) begin
                if (wb_valid[p] && wb_reg[p*5 +: 5] == 5'(r) && busy_q[r] &&
                    tag_q[r] == wb_unit[p*UNIT_W +: UNIT_W]) begin
                    wb_hit[r] = 1'b1;
                    wb_dat[r] = wb_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Operand fetch with writeback bypass
    always_comb begin
        op_rs[0] = id_rs1;
        op_rs[1] = id_rs2;
        for (int k = 0; k < 2; k++) begin
            op_val[k] = '0;
            op_tag[k] = '0;
            if (op_rs[k] == 5'd0) begin
                op_val[k] = '0;
            end else if (wb_hit[op_rs[k]]) begin
                op_val[k] = wb_dat[op_rs[k]];
            end else if (busy_q[op_rs[k]]) begin
                op_tag[k] = tag_q[op_rs[k]];
            end else begin
                op_val[k] = regs_q[op_rs[k]];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (issue && is_jmp) state_d = ST_BR_WAIT;
            ST_BR_WAIT: if (br_resolve) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    // Scoreboard, register file, unit tracking and issue registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < int'(N_REG); r++) begin
                regs_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q      <= '0;
            unit_busy_q <= '0;
            seq_q       <= CNT_W'(1);
            iss_valid   <= '0;
            iss_seq     <= '0;
            iss_pc      <= '0;
            iss_imm     <= '0;
            iss_opcode  <= '0;
            iss_funct3  <= '0;
            iss_rd      <= '0;
            iss_rs1_val <= '0;
            iss_rs2_val <= '0;
            iss_rs1_tag <= '0;
            iss_rs2_tag <= '0;
            iss_jflag   <= 1'b0;
        end else begin
            iss_valid <= '0;
            for (int r = 1; r < int'(N_REG); r++) begin
                if (wb_hit[r]) begin
                    regs_q[r] <= wb_dat[r];
                    busy_q[r] <= 1'b0;
                end
            end
            // A new producer of rd overrides a same-cycle writeback clear
            if (rd_set) begin
                busy_q[id_rd] <= 1'b1;
                tag_q[id_rd]  <= sel_tag;
            end
            unit_busy_q <= (unit_busy_q & ~unit_free) | (issue ? sel_onehot : '0);
            if (issue) begin
                iss_valid   <= sel_onehot;
                iss_seq     <= seq_q;
                iss_pc      <= id_pc;
                iss_imm     <= id_imm;
                iss_opcode  <= id_opcode;
                iss_funct3  <= id_funct3;
                iss_rd      <= id_rd;
                iss_rs1_val <= op_val[0];
                iss_rs2_val <= op_val[1];
                iss_rs1_tag <= op_tag[0];
                iss_rs2_tag <= op_tag[1];
                iss_jflag   <= is_jmp;
                seq_q       <= seq_next;
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard_n.sv
// Directed bench for issue_scoreboard_n with default parameters.
module tb_issue_scoreboard_n;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_FNC  = 7'b0001111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [31:0] id_pc = '0;
    logic [6:0]  id_opcode = '0;
    logic [2:0]  id_funct3 = '0;
    logic [31:0] id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [1:0]  wb_valid = '0;
    logic [9:0]  wb_reg = '0;
    logic [63:0] wb_data = '0;
    logic [5:0]  wb_unit = '0;
    logic [3:0]  unit_free = '0;
    logic        br_resolve = 1'b0;
    logic [3:0]  iss_valid;
    logic [3:0]  iss_seq;
    logic [31:0] iss_pc, iss_imm;
    logic [6:0]  iss_opcode;
    logic [2:0]  iss_funct3;
    logic [4:0]  iss_rd;
    logic [31:0] iss_rs1_val, iss_rs2_val;
    logic [2:0]  iss_rs1_tag, iss_rs2_tag;
    logic        iss_jflag;

    int n_checks = 0;
    int n_errors = 0;

    issue_scoreboard_n dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_unit(wb_unit),
        .unit_free(unit_free), .br_resolve(br_resolve),
        .iss_valid(iss_valid), .iss_seq(iss_seq), .iss_pc(iss_pc), .iss_imm(iss_imm),
        .iss_opcode(iss_opcode), .iss_funct3(iss_funct3), .iss_rd(iss_rd),
        .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
        .iss_rs1_tag(iss_rs1_tag), .iss_rs2_tag(iss_rs2_tag), .iss_jflag(iss_jflag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid   = 1'b0;
        wb_valid   = '0;
        unit_free  = '0;
        br_resolve = 1'b0;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] pc);
        id_valid  = 1'b1;
        id_opcode = op;
        id_funct3 = 3'd0;
        id_rd     = rd;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_imm    = imm;
        id_pc     = pc;
    endtask

    task automatic set_wb(input int p, input logic [4:0] r, input logic [2:0] u, input logic [31:0] d);
        wb_valid[p]        = 1'b1;
        wb_reg[p*5 +: 5]   = r;
        wb_unit[p*3 +: 3]  = u;
        wb_data[p*32 +: 32] = d;
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #2;
        n_checks++; if (iss_valid !== 4'b0000) begin n_errors++; $display("FAIL reset_valid: got %b want 0000", iss_valid); end
        n_checks++; if (iss_seq !== 4'd0) begin n_errors++; $display("FAIL reset_seq: got %0d want 0", iss_seq); end
        n_checks++; if (id_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", id_ready); end
        reset_dut();
    endtask

    task automatic test_first_issue();
        reset_dut();
        drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h100);
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL first_ready: got %b want 1", id_ready); end
        tick();
        n_checks++; if (iss_valid !== 4'b0001) begin n_errors++; $display("FAIL first_valid: got %b want 0001", iss_valid); end
        n_checks++; if (iss_seq !== 4'd1) begin n_errors++; $display("FAIL first_seq: got %0d want 1", iss_seq); end
        n_checks++; if (iss_rs1_val !== 32'd0 || iss_rs1_tag !== 3'd0) begin n_errors++; $display("FAIL first_rs1: got %h/%0d want 0/0", iss_rs1_val, iss_rs1_tag); end
        n_checks++; if (iss_imm !== 32'd5 || iss_rd !== 5'd1 || iss_pc !== 32'h100) begin n_errors++; $display("FAIL first_fields: got imm %0d rd %0d pc %h want 5 1 100", iss_imm, iss_rd, iss_pc); end
        drive(OP_ADD, 5'd2, 5'd1, 5'd0, 32'd0, 32'h104);
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL dep_ready: got %b want 1", id_ready); end
        tick();
        n_checks++; if (iss_valid !== 4'b0010 || iss_seq !== 4'd2) begin n_errors++; $display("FAIL dep_valid: got %b seq %0d want 0010 seq 2", iss_valid, iss_seq); end
        n_checks++; if (iss_rs1_tag !== 3'd1 || iss_rs1_val !== 32'd0) begin n_errors++; $display("FAIL dep_rs1: got tag %0d val %h want 1 0", iss_rs1_tag, iss_rs1_val); end
        idle();
        tick();
        n_checks++; if (iss_valid !== 4'b0000) begin n_errors++; $display("FAIL valid_drop: got %b want 0000", iss_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v;
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            drive(OP_ADDI, 5'(2 + k), 5'd0, 5'd0, 32'(k), 32'h200 + 32'(4 * k));
            #1;
            n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready%0d: got %b want 1", k, id_ready); end
            tick();
            exp_v = 4'b0001 << k;
            n_checks++; if (iss_valid !== exp_v || iss_seq !== 4'(k + 1)) begin n_errors++; $display("FAIL b2b_issue%0d: got %b seq %0d want %b seq %0d", k, iss_valid, iss_seq, exp_v, k + 1); end
        end
        drive(OP_ADDI, 5'd5, 5'd0, 5'd0, 32'd9, 32'h20c);
        #1;
        n_checks++; if (id_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_full: got %b want 0", id_ready); end
        tick();
        n_checks++; if (iss_valid !== 4'b0000) begin n_errors++; $display("FAIL b2b_held: got %b want 0000", iss_valid); end
        unit_free = 4'b0001;
        #1;
        n_checks++; if (id_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_free_same_cycle: got %b want 0", id_ready); end
        tick();
        unit_free = 4'b0000;
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_after_free: got %b want 1", id_ready); end
        tick();
        n_checks++; if (iss_valid !== 4'b0001 || iss_rd !== 5'd5 || iss_seq !== 4'd4) begin n_errors++; $display("FAIL b2b_fourth: got %b rd %0d seq %0d want 0001 rd 5 seq 4", iss_valid, iss_rd, iss_seq); end
        idle();
    endtask

    task automatic test_bypass();
        reset_dut();
        drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 32'h300);
        tick();
        drive(OP_ADD, 5'd6, 5'd1, 5'd1, 32'd0, 32'h304);
        set_wb(1, 5'd1, 3'd1, 32'h1234);
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL byp_ready: got %b want 1", id_ready); end
        tick();
        wb_valid = '0;
        n_checks++; if (iss_valid !== 4'b0010) begin n_errors++; $display("FAIL byp_valid: got %b want 0010", iss_valid); end
        n_checks++; if (iss_rs1_val !== 32'h1234 || iss_rs2_val !== 32'h1234) begin n_errors++; $display("FAIL byp_vals: got %h %h want 1234 1234", iss_rs1_val, iss_rs2_val); end
        n_checks++; if (iss_rs1_tag !== 3'd0 || iss_rs2_tag !== 3'd0) begin n_errors++; $display("FAIL byp_tags: got %0d %0d want 0 0", iss_rs1_tag, iss_rs2_tag); end
        drive(OP_ADD, 5'd8, 5'd1, 5'd0, 32'd0, 32'h308);
        tick();
        n_checks++; if (iss_valid !== 4'b0100 || iss_rs1_val !== 32'h1234 || iss_rs1_tag !== 3'd0) begin n_errors++; $display("FAIL rf_write: got %b %h tag %0d want 0100 1234 tag 0", iss_valid, iss_rs1_val, iss_rs1_tag); end
        idle();
    endtask

    task automatic test_collision();
        reset_dut();
        drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 32'h400);
        tick();
        drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2, 32'h404);
        set_wb(0, 5'd1, 3'd1, 32'h55);
        tick();
        wb_valid = '0;
        n_checks++; if (iss_valid !== 4'b0010) begin n_errors++; $display("FAIL coll_valid: got %b want 0010", iss_valid); end
        drive(OP_ADD, 5'd3, 5'd1, 5'd0, 32'd0, 32'h408);
        set_wb(0, 5'd1, 3'd1, 32'h99);
        tick();
        wb_valid = '0;
        n_checks++; if (iss_rs1_tag !== 3'd2 || iss_rs1_val !== 32'd0) begin n_errors++; $display("FAIL coll_tag: got tag %0d val %h want 2 0", iss_rs1_tag, iss_rs1_val); end
        id_valid  = 1'b0;
        unit_free = 4'b0100;
        tick();
        unit_free = 4'b0000;
        drive(OP_ADD, 5'd4, 5'd1, 5'd0, 32'd0, 32'h40c);
        set_wb(0, 5'd1, 3'd2, 32'h66);
        set_wb(1, 5'd1, 3'd2, 32'h77);
        tick();
        wb_valid = '0;
        n_checks++; if (iss_valid !== 4'b0100 || iss_rs1_val !== 32'h66 || iss_rs1_tag !== 3'd0) begin n_errors++; $display("FAIL wb_priority: got %b %h tag %0d want 0100 66 tag 0", iss_valid, iss_rs1_val, iss_rs1_tag); end
        idle();
    endtask

    task automatic test_mem();
        reset_dut();
        drive(OP_LW, 5'd7, 5'd0, 5'd0, 32'd16, 32'h500);
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL lw_ready: got %b want 1", id_ready); end
        tick();
        n_checks++; if (iss_valid !== 4'b1000 || iss_opcode !== OP_LW) begin n_errors++; $display("FAIL lw_issue: got %b op %b want 1000 op 0000011", iss_valid, iss_opcode); end
        drive(OP_FNC, 5'd0, 5'd0, 5'd0, 32'd0, 32'h504);
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL nop_ready: got %b want 1", id_ready); end
        tick();
        n_checks++; if (iss_valid !== 4'b0000) begin n_errors++; $display("FAIL nop_no_issue: got %b want 0000", iss_valid); end
        drive(OP_LW, 5'd9, 5'd0, 5'd0, 32'd20, 32'h508);
        #1;
        n_checks++; if (id_ready !== 1'b0) begin n_errors++; $display("FAIL lw2_held: got %b want 0", id_ready); end
        unit_free = 4'b1000;
        tick();
        unit_free = 4'b0000;
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL lw2_ready: got %b want 1", id_ready); end
        tick();
        n_checks++; if (iss_valid !== 4'b1000 || iss_seq !== 4'd2 || iss_rd !== 5'd9) begin n_errors++; $display("FAIL lw2_issue: got %b seq %0d rd %0d want 1000 seq 2 rd 9", iss_valid, iss_seq, iss_rd); end
        idle();
    endtask

    task automatic test_branch();
        reset_dut();
        br_resolve = 1'b1;
        tick();
        br_resolve = 1'b0;
        drive(OP_BEQ, 5'd0, 5'd0, 5'd0, 32'd8, 32'h600);
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL beq_ready: got %b want 1", id_ready); end
        tick();
        n_checks++; if (iss_jflag !== 1'b1 || iss_valid !== 4'b0001) begin n_errors++; $display("FAIL beq_issue: got jflag %b valid %b want 1 0001", iss_jflag, iss_valid); end
        drive(OP_ADDI, 5'd10, 5'd0, 5'd0, 32'd3, 32'h604);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (id_ready !== 1'b0) begin n_errors++; $display("FAIL br_wait%0d: got %b want 0", i, id_ready); end
            tick();
        end
        br_resolve = 1'b1;
        #1;
        n_checks++; if (id_ready !== 1'b0) begin n_errors++; $display("FAIL br_resolve_cycle: got %b want 0", id_ready); end
        tick();
        br_resolve = 1'b0;
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL br_resumed: got %b want 1", id_ready); end
        tick();
        n_checks++; if (iss_valid !== 4'b0010 || iss_jflag !== 1'b0 || iss_rd !== 5'd10) begin n_errors++; $display("FAIL br_after: got %b jflag %b rd %0d want 0010 0 10", iss_valid, iss_jflag, iss_rd); end
        idle();
    endtask

    task automatic test_seq_wrap();
        logic [3:0] exp_seq;
        logic [3:0] exp_v;
        reset_dut();
        unit_free = 4'b0111;
        for (int k = 0; k < 16; k++) begin
            drive(OP_ADDI, 5'd0, 5'd0, 5'd0, 32'(k), 32'h700 + 32'(4 * k));
            tick();
            exp_seq = (k < 15) ? 4'(k + 1) : 4'd1;
            exp_v   = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            n_checks++; if (iss_seq !== exp_seq || iss_valid !== exp_v) begin n_errors++; $display("FAIL seq%0d: got seq %0d valid %b want seq %0d valid %b", k, iss_seq, iss_valid, exp_seq, exp_v); end
        end
        drive(OP_ADDI, 5'd5, 5'd0, 5'd0, 32'd1, 32'h800);
        tick();
        drive(OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd2, 32'h804);
        rst = 1'b0;
        #1;
        n_checks++; if (iss_valid !== 4'b0000 || iss_seq !== 4'd0) begin n_errors++; $display("FAIL async_rst: got valid %b seq %0d want 0000 0", iss_valid, iss_seq); end
        rst = 1'b1;
        unit_free = 4'b0000;
        drive(OP_ADD, 5'd6, 5'd5, 5'd0, 32'd0, 32'h808);
        tick();
        n_checks++; if (iss_valid !== 4'b0001 || iss_seq !== 4'd1 || iss_rs1_tag !== 3'd0) begin n_errors++; $display("FAIL post_rst: got %b seq %0d tag %0d want 0001 seq 1 tag 0", iss_valid, iss_seq, iss_rs1_tag); end
        idle();
    endtask

    initial begin
        test_reset();
        test_first_issue();
        test_back_to_back();
        test_bypass();
        test_collision();
        test_mem();
        test_branch();
        test_seq_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
